fifo_rd_stream: RTL and testbench

Single-clock read-side engine that sits on the read port of the dual-clock FIFO in the read clock domain. It issues FIFO read strobes, absorbs the FIFO's one-cycle registered read latency into a small output buffer, and presents the words as a valid/ready stream at one word per cycle. It also provides enable and flush control, with flush discarding all visible FIFO contents.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_stream_buf.sv | 73 +++++++
 rtl/fifo_rd_stream.sv | 167 ++++++++++++++++
 tb/tb_fifo_rd_stream.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared types and default sizes for the FIFO read-side stream engine.
//   Imported by fifo_rd_stream and fifo_rd_stream_buf.
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int BUF_DEPTH_DEF  = 2;
   localparam int STAT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } rd_stream_state_e;

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream_buf
//   BUF_DEPTH-entry circular buffer that holds words returned by the FIFO
//   until the stream sink accepts them.
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset (clears contents too)
//   clear_i        drop all entries (pointers and occupancy to 0)
//   push_i         write push_data_i at tail
//   push_data_i    word to store
//   pop_i          advance head
//   head_data_o    word at head
//   occ_o          number of stored words, 0..BUF_DEPTH
module fifo_rd_stream_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             clear_i,
   input  logic                             push_i,
   input  logic [DATA_WIDTH-1:0]            push_data_i,
   input  logic                             pop_i,
   output logic [DATA_WIDTH-1:0]            head_data_o,
   output logic [$clog2(BUF_DEPTH+1)-1:0]   occ_o
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]      head_q;
   logic [PTR_W-1:0]      tail_q;
   logic [OCC_W-1:0]      occ_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clear_i) begin
         // contents are left stale; nothing is visible while occ is 0
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[tail_q] <= push_data_i;
            tail_q        <= ptr_inc(tail_q);
         end
         if (pop_i) begin
            head_q <= ptr_inc(head_q);
         end
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head_data_o = mem_q[head_q];
   assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side engine for the dual-clock FIFO (read clock domain). Issues
//   read strobes, absorbs the FIFO's one-cycle read latency in a small
//   buffer and presents the words as a valid/ready stream at full rate.
//   Optional statistics counters are built when FIFO_RD_STREAM_STATS_EN
//   is defined.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   en_i              level, 1 = fetch from FIFO
//   flush_i           pulse, discard buffered and FIFO-visible data
//   fifo_rd_en_o      FIFO read strobe
//   fifo_rdata_i      FIFO read data, valid the cycle after a strobe
//   fifo_empty_i      FIFO empty flag (registered)
//   fifo_rd_error_i   FIFO illegal-read pulse
//   m_valid_o/m_ready_i/m_data_o   output stream
//   busy_o            engine active or holding/awaiting data
//   flush_done_o      one-cycle pulse as flush completes
//   err_o             sticky FIFO read-error flag
//   beat_cnt_o        (STATS only) accepted stream beats, wraps
//   drop_cnt_o        (STATS only) words discarded during flush, wraps
//
// state | meaning
// IDLE  | no strobes; buffered words still drain to the stream
// RUN   | strobing the FIFO whenever the buffer has room
// FLUSH | strobing until FIFO empty, all returned words discarded
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BUF_DEPTH  = BUF_DEPTH_DEF
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   parameter int STAT_WIDTH = STAT_WIDTH_DEF
`endif
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  flush_i,
   output logic                  fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   input  logic                  fifo_empty_i,
   input  logic                  fifo_rd_error_i,
   output logic                  m_valid_o,
   input  logic                  m_ready_i,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic                  busy_o,
   output logic                  flush_done_o,
   output logic                  err_o
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] beat_cnt_o,
   output logic [STAT_WIDTH-1:0] drop_cnt_o
`endif
);

   localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
   localparam int FILL_W = OCC_W + 1;

   rd_stream_state_e state_q, state_d;
   logic             inflight_q;
   logic             err_q;

   logic [OCC_W-1:0]      occ;
   logic [DATA_WIDTH-1:0] head_data;
   logic [FILL_W-1:0]     fill;
   logic                  valid;
   logic                  pop;
   logic                  push;
   logic                  clear;
   logic                  rd_en;
   logic                  flush_done;

   always_comb begin
      valid = (occ != '0) && (state_q != FLUSH);
      pop   = valid && m_ready_i;
      // occupancy once the in-flight word lands and this cycle's pop leaves;
      // a strobe is only allowed if its word is guaranteed a slot
      fill  = FILL_W'(occ) + FILL_W'(inflight_q) - FILL_W'(pop);
      case (state_q)
         RUN:     rd_en = !fifo_empty_i && (fill < FILL_W'(BUF_DEPTH));
         FLUSH:   rd_en = !fifo_empty_i;
         default: rd_en = 1'b0;
      endcase
      push       = inflight_q && (state_q != FLUSH);
      flush_done = (state_q == FLUSH) && fifo_empty_i && !inflight_q;
      // entering FLUSH clears the buffer, overriding any same-cycle capture
      clear      = (state_q != FLUSH) && flush_i;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (flush_i)   state_d = FLUSH;
            else if (en_i) state_d = RUN;
         end
         RUN: begin
            if (flush_i)    state_d = FLUSH;
            else if (!en_i) state_d = IDLE;
         end
         FLUSH: begin
            if (flush_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rd_en;
         err_q      <= err_q | fifo_rd_error_i;
      end
   end

   fifo_rd_stream_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (clear),
      .push_i      (push),
      .push_data_i (fifo_rdata_i),
      .pop_i       (pop),
      .head_data_o (head_data),
      .occ_o       (occ)
   );

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [STAT_WIDTH-1:0] beat_cnt_q;
   logic [STAT_WIDTH-1:0] drop_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         beat_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         if (pop) begin
            beat_cnt_q <= beat_cnt_q + STAT_WIDTH'(1);
         end
         // only words returned while in FLUSH count; buffered words cleared
         // on entry do not
         if ((state_q == FLUSH) && inflight_q) begin
            drop_cnt_q <= drop_cnt_q + STAT_WIDTH'(1);
         end
      end
   end

   assign beat_cnt_o = beat_cnt_q;
   assign drop_cnt_o = drop_cnt_q;
`endif

   assign fifo_rd_en_o = rd_en;
   assign m_valid_o    = valid;
   assign m_data_o     = head_data;
   assign busy_o       = (state_q != IDLE) || (occ != '0) || inflight_q;
   assign flush_done_o = flush_done;
   assign err_o        = err_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       en_i = 1'b0;
   logic       flush_i = 1'b0;
   logic       fifo_rd_en_o;
   logic [7:0] fifo_rdata_i = 8'h00;
   logic       fifo_empty_i = 1'b1;
   logic       fifo_rd_error_i = 1'b0;
   logic       m_valid_o;
   logic       m_ready_i = 1'b0;
   logic [7:0] m_data_o;
   logic       busy_o;
   logic       flush_done_o;
   logic       err_o;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [15:0] beat_cnt_o;
   logic [15:0] drop_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   fifo_rd_stream dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .en_i            (en_i),
      .flush_i         (flush_i),
      .fifo_rd_en_o    (fifo_rd_en_o),
      .fifo_rdata_i    (fifo_rdata_i),
      .fifo_empty_i    (fifo_empty_i),
      .fifo_rd_error_i (fifo_rd_error_i),
      .m_valid_o       (m_valid_o),
      .m_ready_i       (m_ready_i),
      .m_data_o        (m_data_o),
      .busy_o          (busy_o),
      .flush_done_o    (flush_done_o),
      .err_o           (err_o)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .beat_cnt_o      (beat_cnt_o),
      .drop_cnt_o      (drop_cnt_o)
`endif
   );

   int total = 0;
   int bad = 0;
   int done_cnt = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];

   logic       s_rd_en, s_valid, s_busy, s_done, s_err;
   logic [7:0] s_data;

   typedef struct {
      logic [7:0] load_base;
      int         load_n;
      logic       en;
      logic       ready;
      logic       exp_rd_en;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock: sample outputs at negedge, scoreboard beats, then update FIFO model
   task automatic tick();
      @(negedge clk_i);
      s_rd_en = fifo_rd_en_o;
      s_valid = m_valid_o;
      s_data  = m_data_o;
      s_busy  = busy_o;
      s_done  = flush_done_o;
      s_err   = err_o;
      if (s_done === 1'b1) done_cnt++;
      if (m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra_beat: got %0h expected no beat", m_data_o);
         end else begin
            chk("sb_data", m_data_o, exp_q.pop_front());
         end
      end
      @(posedge clk_i);
      #1;
      if (s_rd_en === 1'b1) begin
         if (fifo_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_of_empty: got strobe expected none");
         end else begin
            fifo_rdata_i = fifo_q.pop_front();
         end
      end
      fifo_empty_i = (fifo_q.size() == 0);
   endtask

   task automatic load(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         fifo_q.push_back(base + 8'(i));
         exp_q.push_back(base + 8'(i));
      end
      fifo_empty_i = (fifo_q.size() == 0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      en_i = 1'b0;
      flush_i = 1'b0;
      m_ready_i = 1'b0;
      fifo_rd_error_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      fifo_empty_i = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "timeout");
   end

   initial begin
      // streaming 0x11..0x15 then an 8-word stall (ready low) sequence
      vecs[0]  = '{8'h11, 5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[2]  = '{8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
      vecs[3]  = '{8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h12};
      vecs[4]  = '{8'h00, 0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h13};
      vecs[5]  = '{8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14};
      vecs[6]  = '{8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h15};
      vecs[7]  = '{8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[8]  = '{8'hA0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[9]  = '{8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[10] = '{8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};
      vecs[11] = '{8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0};

      // reset state
      do_reset();
      tick();
      chk("rst_rd_en", s_rd_en, 1'b0);
      chk("rst_valid", s_valid, 1'b0);
      chk("rst_data", s_data, 8'h00);
      chk("rst_busy", s_busy, 1'b0);
      chk("rst_done", s_done, 1'b0);
      chk("rst_err", s_err, 1'b0);

      // streaming and backpressure table
      en_i = 1'b1;
      tick();
      chk("en_idle_rd_en", s_rd_en, 1'b0);
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].load_n > 0) load(vecs[i].load_base, vecs[i].load_n);
         en_i = vecs[i].en;
         m_ready_i = vecs[i].ready;
         tick();
         chk($sformatf("vec%0d_rd_en", i), s_rd_en, vecs[i].exp_rd_en);
         chk($sformatf("vec%0d_valid", i), s_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) chk($sformatf("vec%0d_data", i), s_data, vecs[i].exp_data);
      end
      m_ready_i = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      chk("stall_all_delivered", exp_q.size(), 0);
      chk("stall_fifo_drained", fifo_q.size(), 0);
      tick();
      chk("stall_end_valid", s_valid, 1'b0);
      chk("stall_end_rd_en", s_rd_en, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("beat_cnt", beat_cnt_o, 16'd13);
`endif

      // en_i dropped with a strobe in flight
      do_reset();
      en_i = 1'b1;
      tick();
      load(8'h31, 3);
      m_ready_i = 1'b1;
      en_i = 1'b0;
      tick();
      chk("endrop_c0_rd_en", s_rd_en, 1'b1);
      tick();
      chk("endrop_c1_rd_en", s_rd_en, 1'b0);
      chk("endrop_c1_valid", s_valid, 1'b0);
      tick();
      chk("endrop_c2_valid", s_valid, 1'b1);
      chk("endrop_c2_data", s_data, 8'h31);
      chk("endrop_c2_busy", s_busy, 1'b1);
      tick();
      chk("endrop_c3_valid", s_valid, 1'b0);
      chk("endrop_c3_busy", s_busy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("endrop_no_strobe", s_rd_en, 1'b0);
      end
      chk("endrop_fifo_left", fifo_q.size(), 2);

      // flush with 2 buffered and 6 in FIFO
      do_reset();
      en_i = 1'b1;
      tick();
      load(8'h40, 8);
      m_ready_i = 1'b0;
      tick();
      tick();
      tick();
      flush_i = 1'b1;
      en_i = 1'b0;
      tick();
      chk("flush_pre_valid", s_valid, 1'b1);
      chk("flush_pre_data", s_data, 8'h40);
      chk("flush_pre_rd_en", s_rd_en, 1'b0);
      flush_i = 1'b0;
      exp_q.delete();
      done_cnt = 0;
      m_ready_i = 1'b1;
      tick();
      chk("flush_valid_off", s_valid, 1'b0);
      chk("flush_rd_en", s_rd_en, 1'b1);
      for (int i = 0; i < 20; i++) tick();
      chk("flush_done_pulses", done_cnt, 1);
      chk("flush_fifo_drained", fifo_q.size(), 0);
      chk("flush_end_busy", s_busy, 1'b0);
      chk("flush_end_valid", s_valid, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("drop_cnt", drop_cnt_o, 16'd6);
      chk("flush_beat_cnt", beat_cnt_o, 16'd0);
`endif

      // sticky error
      do_reset();
      tick();
      chk("err_before", s_err, 1'b0);
      fifo_rd_error_i = 1'b1;
      tick();
      fifo_rd_error_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("err_sticky", s_err, 1'b1);
      end
      do_reset();
      tick();
      chk("err_cleared", s_err, 1'b0);

      // reset mid-stream with buffered data and a strobe in flight
      do_reset();
      en_i = 1'b1;
      tick();
      load(8'h60, 8);
      m_ready_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      en_i = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      fifo_empty_i = 1'b1;
      tick();
      chk("midrst_rd_en", s_rd_en, 1'b0);
      chk("midrst_valid", s_valid, 1'b0);
      chk("midrst_data", s_data, 8'h00);
      chk("midrst_busy", s_busy, 1'b0);
      chk("midrst_done", s_done, 1'b0);
      chk("midrst_err", s_err, 1'b0);
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("midrst_beat", beat_cnt_o, 16'd0);
      chk("midrst_drop", drop_cnt_o, 16'd0);
`endif
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst_word_ignored", s_valid, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
